dram_read_dispatcher: RTL and testbench

Consumes the 40-bit read-request stream produced by the DRAM read requester's clock-domain FIFO and turns each entry into one 128-bit DRAM line read. Returned lines are streamed out in request order, each tagged with its sample period and intra-line offset, for the per-instrument sample buffers. Sits entirely in the DRAM-controller clock domain, between the address FIFO receiver port and the memory controller's read command/response ports. Limits in-flight reads with a credit counter so the response buffer can never overflow.

---
 rtl/dram_read_dispatcher.sv | 107 ++++++++++
 tb/tb_dram_read_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_dispatcher.sv
// dram_read_dispatcher: turns sample read requests into tagged DRAM line reads and streams
// the returned lines back in request order, bounded by a credit counter.
module dram_read_dispatcher #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W = 4
) (
  input  logic                               clk_dram_ctrl,
  input  logic                               rst_n,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [39:0]                        s_axis_tdata,
  input  logic                               s_axis_tlast,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [20:0]                        cmd_addr,
  output logic [TAG_W-1:0]                   cmd_tag,
  input  logic                               rsp_valid,
  input  logic [127:0]                       rsp_data,
  input  logic [TAG_W-1:0]                   rsp_tag,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [127:0]                       m_axis_tdata,
  output logic [16:0]                        m_axis_tuser,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_tag
);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int PW = AW + 1;
  localparam int MW = TAG_W + 17;
  localparam int DW = 128 + 17;
  localparam logic [PW-1:0] MAX_C = PW'(MAX_OUTSTANDING);

  logic [PW-1:0]    outstanding_q, outstanding_d;
  logic [TAG_W-1:0] tag_ctr_q, tag_ctr_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [20:0]      cmd_addr_q, cmd_addr_d;
  logic [TAG_W-1:0] cmd_tag_q, cmd_tag_d;
  logic             err_tag_q, err_tag_d;
  logic [PW-1:0]    mwr_q, mwr_d, mrd_q, mrd_d, dwr_q, dwr_d, drd_q, drd_d;
  logic [MW-1:0]    meta_mem [MAX_OUTSTANDING];
  logic [DW-1:0]    data_mem [MAX_OUTSTANDING];
  logic [MW-1:0]    meta_head;
  logic             s_fire, m_fire, meta_empty, data_empty, push_data;
  logic             unused_ok;

  assign unused_ok = ^{s_axis_tlast, s_axis_tdata[39:38]};

  // Metadata entries are {tag, addr[2:0], sample_period}; a response pops one whether or not its tag matches
  always_comb begin
    meta_empty = mwr_q == mrd_q;
    data_empty = dwr_q == drd_q;
    meta_head = meta_mem[mrd_q[AW-1:0]];
    s_axis_tready = rst_n && outstanding_q < MAX_C && (!cmd_valid_q || cmd_ready);
    s_fire = s_axis_tvalid && s_axis_tready;
    m_fire = !data_empty && m_axis_tready;
    push_data = rsp_valid && !meta_empty;
    outstanding_d = outstanding_q + PW'(s_fire) - PW'(m_fire);
    tag_ctr_d = s_fire ? tag_ctr_q + TAG_W'(1) : tag_ctr_q;
    cmd_valid_d = s_fire || (cmd_valid_q && !cmd_ready);
    cmd_addr_d = s_fire ? s_axis_tdata[23:3] : cmd_addr_q;
    cmd_tag_d = s_fire ? tag_ctr_q : cmd_tag_q;
    err_tag_d = err_tag_q || (rsp_valid && (meta_empty || meta_head[MW-1 -: TAG_W] != rsp_tag));
    mwr_d = mwr_q + PW'(s_fire);
    mrd_d = mrd_q + PW'(push_data);
    dwr_d = dwr_q + PW'(push_data);
    drd_d = drd_q + PW'(m_fire);
  end

  always_ff @(posedge clk_dram_ctrl or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      tag_ctr_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_tag_q <= '0;
      err_tag_q <= 1'b0;
      mwr_q <= '0;
      mrd_q <= '0;
      dwr_q <= '0;
      drd_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      tag_ctr_q <= tag_ctr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_tag_q <= cmd_tag_d;
      err_tag_q <= err_tag_d;
      mwr_q <= mwr_d;
      mrd_q <= mrd_d;
      dwr_q <= dwr_d;
      drd_q <= drd_d;
    end
  end

  always_ff @(posedge clk_dram_ctrl) begin
    if (s_fire) meta_mem[mwr_q[AW-1:0]] <= {tag_ctr_q, s_axis_tdata[2:0], s_axis_tdata[37:24]};
    if (push_data) data_mem[dwr_q[AW-1:0]] <= {rsp_data, meta_head[16:0]};
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_tag = cmd_tag_q;
  assign m_axis_tvalid = !data_empty;
  assign {m_axis_tdata, m_axis_tuser} = data_mem[drd_q[AW-1:0]];
  assign outstanding = outstanding_q;
  assign err_tag = err_tag_q;
endmodule

// File: tb/tb_dram_read_dispatcher.sv
// tb_dram_read_dispatcher: table vectors, hand-written corner sequences and a random run
// checked against a queue-based model of requests, commands, responses and returned lines.
module tb_dram_read_dispatcher;
  localparam int MAXO = 8;
  localparam int TW = 4;

  logic clk, rst_n;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [39:0] s_axis_tdata;
  logic cmd_valid, cmd_ready;
  logic [20:0] cmd_addr;
  logic [TW-1:0] cmd_tag, rsp_tag;
  logic rsp_valid;
  logic [127:0] rsp_data, m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready;
  logic [16:0] m_axis_tuser;
  logic [$clog2(MAXO):0] outstanding;
  logic err_tag;

  dram_read_dispatcher #(.MAX_OUTSTANDING(MAXO), .TAG_W(TW)) dut (
    .clk_dram_ctrl(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .outstanding(outstanding), .err_tag(err_tag)
  );

  typedef struct packed { logic [20:0] line; logic [TW-1:0] tag; } cmd_t;
  typedef struct packed { logic [TW-1:0] tag; logic [2:0] off; logic [13:0] per; } pend_t;
  typedef struct packed { logic [127:0] data; logic [16:0] user; } line_t;
  typedef struct {
    logic [23:0] addr; logic [13:0] per; logic [1:0] hi; logic [127:0] data;
    logic [20:0] exp_line; logic [16:0] exp_user;
  } vec_t;

  cmd_t cmd_q[$];
  pend_t pend_q[$];
  line_t out_q[$];
  logic [TW-1:0] mem_q[$];
  int n_acc, credits, total, bad;
  bit err_exp, exp_rdy, sf, mf, auto_rsp, rsp_rand;
  vec_t tv[4];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [39:0] rnd40();
    return 40'({$urandom, $urandom});
  endfunction

  // Reference model: updated at the falling edge from the handshakes the next rising edge will see
  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_q.delete(); pend_q.delete(); out_q.delete(); mem_q.delete();
      n_acc = 0; credits = 0; err_exp = 0;
      chk("rst_s_ready", s_axis_tready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_m_valid", m_axis_tvalid, 0);
    end else begin
      exp_rdy = credits < MAXO && (cmd_q.size() == 0 || cmd_ready);
      sf = s_axis_tvalid && exp_rdy;
      mf = out_q.size() != 0 && m_axis_tready;
      chk("s_ready", s_axis_tready, exp_rdy);
      chk("cmd_valid", cmd_valid, cmd_q.size() != 0);
      chk("m_valid", m_axis_tvalid, out_q.size() != 0);
      chk("outstanding", outstanding, credits);
      chk("err_tag", err_tag, err_exp);
      if (cmd_q.size() != 0 && cmd_ready) begin
        chk("cmd_addr", cmd_addr, cmd_q[0].line);
        chk("cmd_tag", cmd_tag, cmd_q[0].tag);
        mem_q.push_back(cmd_q[0].tag);
        void'(cmd_q.pop_front());
      end
      if (mf) begin
        chk("m_tdata", m_axis_tdata, out_q[0].data);
        chk("m_tuser", m_axis_tuser, out_q[0].user);
        void'(out_q.pop_front());
      end
      if (rsp_valid) begin
        if (pend_q.size() == 0) err_exp = 1;
        else begin
          if (pend_q[0].tag != rsp_tag) err_exp = 1;
          out_q.push_back('{rsp_data, {pend_q[0].off, pend_q[0].per}});
          void'(pend_q.pop_front());
        end
      end
      if (sf) begin
        cmd_q.push_back('{s_axis_tdata[23:3], TW'(n_acc)});
        pend_q.push_back('{TW'(n_acc), s_axis_tdata[2:0], s_axis_tdata[37:24]});
        n_acc++;
      end
      credits += int'(sf) - int'(mf);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    rsp_valid = 0;
    if (auto_rsp && mem_q.size() != 0 && (!rsp_rand || $urandom_range(0, 3) != 0)) begin
      rsp_valid = 1;
      rsp_tag = mem_q[0];
      rsp_data = rnd128();
      void'(mem_q.pop_front());
    end
  endtask

  task automatic send_reqs(input int n);
    int sent = 0;
    for (int c = 0; c < 400 && sent < n; c++) begin
      step();
      s_axis_tvalid = 1;
      s_axis_tdata = rnd40();
      @(negedge clk);
      if (s_axis_tready) sent++;
    end
    step();
    s_axis_tvalid = 0;
    chk("send_count", sent, n);
  endtask

  task automatic wait_idle();
    s_axis_tvalid = 0; cmd_ready = 1; m_axis_tready = 1; auto_rsp = 1;
    for (int c = 0; c < 500 && !(credits == 0 && cmd_q.size() == 0); c++) step();
    @(negedge clk);
    chk("idle_outstanding", outstanding, 0);
    step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 0;
    #1;
    chk("areset_cmd_valid", cmd_valid, 0);
    chk("areset_m_valid", m_axis_tvalid, 0);
    chk("areset_outstanding", outstanding, 0);
    chk("areset_err", err_tag, 0);
    chk("areset_s_ready", s_axis_tready, 0);
    s_axis_tvalid = 0;
    repeat (3) step();
    rst_n = 1;
  endtask

  initial begin
    int acc;
    logic [TW-1:0] bad_tag;
    rst_n = 0; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_tag = '0; m_axis_tready = 0;
    total = 0; bad = 0; auto_rsp = 0; rsp_rand = 0;
    tv[0] = '{24'h000013, 14'd2272, 2'b00, 128'h0123456789abcdef_fedcba9876543210, 21'h000002, {3'd3, 14'd2272}};
    tv[1] = '{24'hffffff, 14'h3fff, 2'b11, 128'hffffffff_00000000_aaaaaaaa_55555555, 21'h1fffff, {3'd7, 14'h3fff}};
    tv[2] = '{24'h000008, 14'd1, 2'b01, 128'h0, 21'h000001, {3'd0, 14'd1}};
    tv[3] = '{24'habcde5, 14'h1234, 2'b10, 128'hdeadbeef_cafef00d_12345678_9abcdef0, 21'h1579bc, {3'd5, 14'h1234}};
    repeat (3) step();
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      step();
      cmd_ready = 0; auto_rsp = 0; m_axis_tready = 0;
      s_axis_tvalid = 1;
      s_axis_tdata = {tv[i].hi, tv[i].per, tv[i].addr};
      @(negedge clk); chk("tv_accept", s_axis_tready, 1);
      step(); s_axis_tvalid = 0;
      @(negedge clk);
      chk("tv_cmd_valid", cmd_valid, 1);
      chk("tv_cmd_addr", cmd_addr, tv[i].exp_line);
      chk("tv_cmd_tag", cmd_tag, TW'(i));
      step(); cmd_ready = 1;
      step(); cmd_ready = 0; rsp_valid = 1; rsp_tag = TW'(i); rsp_data = tv[i].data;
      step();
      @(negedge clk);
      chk("tv_m_valid", m_axis_tvalid, 1);
      chk("tv_tdata", m_axis_tdata, tv[i].data);
      chk("tv_tuser", m_axis_tuser, tv[i].exp_user);
      step(); m_axis_tready = 1;
      step(); m_axis_tready = 0; mem_q.delete();
    end

    do_reset();
    cmd_ready = 1; m_axis_tready = 1; auto_rsp = 1;
    send_reqs(17);
    wait_idle();
    chk("wrap_no_err", err_tag, 0);

    m_axis_tready = 0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      s_axis_tvalid = 1;
      s_axis_tdata = rnd40();
      @(negedge clk);
      if (s_axis_tready) acc++;
    end
    step(); s_axis_tvalid = 0;
    @(negedge clk);
    chk("bp_accepted", acc, MAXO);
    chk("bp_s_ready", s_axis_tready, 0);
    chk("bp_outstanding", outstanding, MAXO);
    step(); m_axis_tready = 1;
    send_reqs(12);
    wait_idle();

    cmd_ready = 0;
    s_axis_tvalid = 1; s_axis_tdata = rnd40();
    @(negedge clk); chk("stall_first_acc", s_axis_tready, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      step(); s_axis_tdata = rnd40();
      @(negedge clk);
      chk("stall_cmd_valid", cmd_valid, 1);
      chk("stall_cmd_tag", cmd_tag, TW'(n_acc - 1));
      chk("stall_s_ready", s_axis_tready, 0);
    end
    step(); cmd_ready = 1;
    repeat (4) step();
    wait_idle();

    do_reset();
    auto_rsp = 0; cmd_ready = 1; m_axis_tready = 1;
    send_reqs(1);
    step();
    bad_tag = ~mem_q[0];
    rsp_valid = 1; rsp_tag = bad_tag; rsp_data = rnd128();
    step();
    @(negedge clk); chk("wrong_tag_err", err_tag, 1);
    repeat (3) step();
    @(negedge clk); chk("wrong_tag_sticky", err_tag, 1);
    step(); mem_q.delete();

    m_axis_tready = 0;
    send_reqs(4);
    repeat (2) step();
    @(negedge clk); chk("inflight_outstanding", outstanding, 4);
    do_reset();
    step(); rsp_valid = 1; rsp_tag = '0; rsp_data = rnd128();
    step();
    @(negedge clk);
    chk("late_rsp_err", err_tag, 1);
    chk("late_rsp_outstanding", outstanding, 0);
    chk("late_rsp_dropped", m_axis_tvalid, 0);
    do_reset();
    cmd_ready = 0;
    send_reqs(1);
    @(negedge clk);
    chk("post_reset_valid", cmd_valid, 1);
    chk("post_reset_tag", cmd_tag, 0);
    step();
    wait_idle();

    do_reset();
    auto_rsp = 1; rsp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      s_axis_tvalid = $urandom_range(0, 9) < 7;
      s_axis_tdata = rnd40();
      cmd_ready = $urandom_range(0, 3) != 0;
      m_axis_tready = $urandom_range(0, 2) != 0;
    end
    step();
    wait_idle();
    chk("final_err", err_tag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
